// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle fetch/decode/execute/mem/writeback sequencer with retired-instruction counter
module cpu_control_fsm #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic             alu_zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic [3:0]       alu_op,
    output logic             alu_src_imm,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [2:0] {FETCH = 3'd0, DECODE, EXECUTE, MEM, WRITEBACK, HALT} state_t;
    logic [2:0]       state_q;
    state_t           state_d;
    logic [3:0]       op_q;
    logic [CNT_W-1:0] count;
    logic             is_rtype, is_load, is_store, is_beq, is_addi, is_nop, is_halt;
    logic [3:0]       exe_op;
    logic             exe_imm;
    assign is_rtype = op_q <= 4'd6;
    assign is_load  = op_q == 4'd7;
    assign is_store = op_q == 4'd8;
    assign is_beq   = op_q == 4'd9;
    assign is_addi  = op_q == 4'd10;
    assign is_nop   = op_q inside {[4'd11:4'd14]};
    assign is_halt  = op_q == 4'd15;
    assign exe_op   = is_rtype ? op_q : is_beq ? 4'd1 : 4'd0;
    assign exe_imm  = is_load | is_store | is_addi;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            op_q    <= 4'd0;
            count   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) op_q <= opcode;
            count <= count + {{(CNT_W-1){1'b0}}, pc_write};
        end
    end
    // Every strobe stays low while reset is high, so an in-flight access is dropped.
    always_comb begin
        state_d     = FETCH;
        imem_req    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        alu_op      = 4'd0;
        alu_src_imm = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                    state_d  = imem_ready ? DECODE : FETCH;
                end
                DECODE: state_d = EXECUTE;
                EXECUTE: begin
                    alu_op      = exe_op;
                    alu_src_imm = exe_imm;
                    pc_write    = is_beq | is_nop;
                    pc_src      = is_beq & alu_zero;
                    state_d     = is_halt ? HALT : (is_load | is_store) ? MEM :
                                  (is_rtype | is_addi) ? WRITEBACK : FETCH;
                end
                MEM: begin
                    alu_op      = exe_op;
                    alu_src_imm = exe_imm;
                    dmem_req    = 1'b1;
                    dmem_we     = is_store;
                    pc_write    = dmem_ready & is_store;
                    state_d     = !dmem_ready ? MEM : is_load ? WRITEBACK : FETCH;
                end
                WRITEBACK: begin
                    reg_write  = 1'b1;
                    mem_to_reg = is_load;
                    pc_write   = 1'b1;
                end
                HALT: state_d = HALT;
                default: state_d = FETCH;
            endcase
        end
    end
    assign halted  = !reset && state_q == HALT;
    assign state   = reset ? 3'd0 : state_q;
    assign retired = reset ? '0 : count;
endmodule
